// File: rtl/arm_pkg.sv
// Shared ARM pipeline types and constants.
// Used by the fetch-side instruction memory.
package arm_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A00000;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-write-port instruction RAM with registered read.
// Contents are not reset.
module imem_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Run-time loadable instruction memory for the fetch stage.
// Load stream fills the RAM, then fetches are served with 1-cycle latency.
module instr_mem_sync
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W    = INSTR_W,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter bit          BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              loaded,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_instr,
  output logic              resp_fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  imem_state_t state, state_d;
  logic [IDX_W-1:0] wp, wp_d;
  logic we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      wp    <= '0;
    end else begin
      state <= state_d;
      wp    <= wp_d;
    end
  end

  always_comb begin
    state_d = state;
    wp_d    = wp;
    we      = 1'b0;
    if (load_start) begin
      state_d = LOAD;
      wp_d    = '0;
    end else if (state == LOAD && load_valid) begin
      we   = 1'b1;
      wp_d = wp + IDX_W'(1);
      if (load_last || wp == LAST_IDX) begin
        state_d = RUN;
        wp_d    = '0;
      end
    end
  end

  // Full-width index so high address bits are range-checked, not dropped.
  logic [ADDR_W-1:0] full_idx;
  logic misalign, fault_c, accept, re;

  always_comb begin
    full_idx = BYTE_ADDR ? (req_addr >> 2) : req_addr;
    misalign = BYTE_ADDR && (req_addr[1:0] != 2'b00);
    fault_c  = misalign || (full_idx >= DEPTH_A);
  end

  assign loaded    = (state == RUN);
  assign req_ready = loaded && !flush && !load_start &&
                     (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign re        = accept && !fault_c;

  logic [DATA_W-1:0] rdata;

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wp),
    .wdata (load_data),
    .re    (re),
    .raddr (full_idx[IDX_W-1:0]),
    .rdata (rdata)
  );

  // RAM read data is only trusted after a good fetch; otherwise NOP.
  logic use_ram;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      use_ram    <= 1'b0;
    end else if (load_start || flush) begin
      resp_valid <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_fault <= fault_c;
      use_ram    <= !fault_c;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign resp_instr = use_ram ? rdata : NOP_WORD;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync.
// Directed tables, corner sequences and a randomized model comparison.
module tb_instr_mem_sync;

  localparam logic [31:0] NOP = 32'hE1A00000;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, load_start, load_valid, load_last;
  logic [31:0] load_data;
  logic        loaded;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_instr;
  logic        resp_fault;

  instr_mem_sync dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_data  (load_data),
    .loaded     (loaded),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_fault (resp_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mem_m [DEPTH];
  int wp_m = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic void model_rd(input logic [31:0] a,
                                   output logic [31:0] ins,
                                   output logic f);
    logic [31:0] idx;
    idx = a >> 2;
    if (a[1:0] != 2'b00 || idx >= DEPTH) begin
      ins = NOP;
      f   = 1'b1;
    end else begin
      ins = mem_m[idx[5:0]];
      f   = 1'b0;
    end
  endfunction

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    mem_m[wp_m] = d;
    wp_m++;
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] a);
    logic [31:0] ei;
    logic ef;
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = 1'b1;
    settle();
    chk({name, "_rdy"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    model_rd(a, ei, ef);
    chk({name, "_vld"}, 32'(resp_valid), 32'd1);
    chk({name, "_ins"}, resp_instr, ei);
    chk({name, "_flt"}, 32'(resp_fault), 32'(ef));
  endtask

  initial begin
    logic [31:0] prog [4];
    logic        ev, ef_m, eready;
    logic [31:0] ei_m;

    prog[0] = 32'hE3A00014;
    prog[1] = 32'hE3A01A01;
    prog[2] = 32'hE3A02103;
    prog[3] = 32'hE0923002;
    vecs[0] = '{32'd0,         prog[0], 1'b0};
    vecs[1] = '{32'd4,         prog[1], 1'b0};
    vecs[2] = '{32'd8,         prog[2], 1'b0};
    vecs[3] = '{32'd12,        prog[3], 1'b0};
    vecs[4] = '{32'd256,       NOP,     1'b1};
    vecs[5] = '{32'd6,         NOP,     1'b1};
    vecs[6] = '{32'h4000_0000, NOP,     1'b1};
    vecs[7] = '{32'd4,         prog[1], 1'b0};
    vecs[8] = '{32'd1,         NOP,     1'b1};

    rst = 1'b1; load_start = 0; load_valid = 0; load_last = 0;
    load_data = '0; req_valid = 1'b1; req_addr = '0;
    flush = 0; resp_ready = 1'b1;
    step(); step();
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_vld", 32'(resp_valid), 32'd0);
    chk("rst_flt", 32'(resp_fault), 32'd0);
    chk("rst_ins", resp_instr, NOP);
    rst = 1'b0;
    step();
    chk("load_rdy", 32'(req_ready), 32'd0);
    req_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      chk("pre_loaded", 32'(loaded), 32'd0);
      load_word(prog[i], i == 3);
    end
    chk("loaded4", 32'(loaded), 32'd1);

    // back-to-back directed table
    resp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1;
      req_addr  = vecs[i].addr;
      settle();
      chk($sformatf("vec%0d_rdy", i), 32'(req_ready), 32'd1);
      step();
      chk($sformatf("vec%0d_vld", i), 32'(resp_valid), 32'd1);
      chk($sformatf("vec%0d_ins", i), resp_instr, vecs[i].instr);
      chk($sformatf("vec%0d_flt", i), 32'(resp_fault),
          32'(vecs[i].fault));
    end
    req_valid = 1'b0;
    step();
    chk("drain_vld", 32'(resp_valid), 32'd0);

    // backpressure hold
    req_valid = 1'b1; req_addr = 32'd4; resp_ready = 1'b0;
    step();
    req_addr = 32'd8;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_rdy", 32'(req_ready), 32'd0);
      chk("hold_vld", 32'(resp_valid), 32'd1);
      chk("hold_ins", resp_instr, prog[1]);
      chk("hold_flt", 32'(resp_fault), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    settle();
    chk("release_rdy", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("release_ins", resp_instr, prog[2]);
    step();

    // flush
    req_valid = 1'b1; req_addr = 32'd0;
    step();
    flush = 1'b1; req_addr = 32'd4;
    settle();
    chk("flush_rdy", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_vld", 32'(resp_valid), 32'd0);
    step();
    chk("flush_noacc", 32'(resp_valid), 32'd0);
    fetch_chk("refetch", 32'd4);
    step();

    // reset mid-load, then full 64-word load without last
    rst = 1'b1; step(); rst = 1'b0; wp_m = 0;
    chk("rst2_loaded", 32'(loaded), 32'd0);
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b0);
    rst = 1'b1; step(); rst = 1'b0; wp_m = 0;
    chk("rst3_loaded", 32'(loaded), 32'd0);
    chk("rst3_vld", 32'(resp_valid), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("w63_loaded", 32'(loaded), 32'd0);
      load_word($urandom(), 1'b0);
    end
    chk("w64_loaded", 32'(loaded), 32'd1);
    fetch_chk("full0", 32'd0);
    fetch_chk("full63", 32'd252);
    step();

    // randomized traffic against the model
    ev = 1'b0; ei_m = '0; ef_m = 1'b0;
    for (int n = 0; n < 500; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      if (r < 7)       req_addr = 32'($urandom_range(0, 63)) << 2;
      else if (r == 7) req_addr = (32'($urandom_range(0, 63)) << 2)
                                  | 32'($urandom_range(1, 3));
      else if (r == 8) req_addr = 32'($urandom_range(64, 200)) << 2;
      else             req_addr = $urandom();
      settle();
      eready = !flush && (!ev || resp_ready);
      chk("rnd_rdy", 32'(req_ready), 32'(eready));
      if (flush) begin
        ev = 1'b0;
      end else if (req_valid && eready) begin
        ev = 1'b1;
        model_rd(req_addr, ei_m, ef_m);
      end else if (resp_ready) begin
        ev = 1'b0;
      end
      step();
      chk("rnd_vld", 32'(resp_valid), 32'(ev));
      if (ev) begin
        chk("rnd_ins", resp_instr, ei_m);
        chk("rnd_flt", 32'(resp_fault), 32'(ef_m));
      end
    end
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    step();

    // load_start in RUN beats a pending fetch
    req_valid = 1'b1; req_addr = 32'd8;
    step();
    load_start = 1'b1; req_addr = 32'd4;
    settle();
    chk("ls_rdy", 32'(req_ready), 32'd0);
    step();
    load_start = 1'b0; req_valid = 1'b0; wp_m = 0;
    chk("ls_loaded", 32'(loaded), 32'd0);
    chk("ls_vld", 32'(resp_valid), 32'd0);
    load_word(32'hCAFE_0001, 1'b0);
    load_word(32'hCAFE_0002, 1'b1);
    chk("ls_reloaded", 32'(loaded), 32'd1);
    load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    step();
    load_valid = 1'b0;
    fetch_chk("new0", 32'd0);
    fetch_chk("new1", 32'd4);
    fetch_chk("old2", 32'd8);
    step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
